// File: rtl/spi_shifter_pkg.sv
// Shared definitions for the SPI byte engine: FSM encodings, DIV default,
// the idle value of the device selects and the MISO line mux.
package spi_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_TRAIL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         DIV_DEFAULT = 2;
  localparam logic [1:0] NSS_IDLE    = 2'b11;

  // Card 0 and card 1 drive MISO when their select is low; the expansion
  // line is only heard while neither card is selected.
  function automatic logic miso_mux(input logic [2:0] miso, input logic [1:0] nss);
    return (miso[0] & ~nss[0]) | (miso[1] & ~nss[1]) | (miso[2] & nss[0] & nss[1]);
  endfunction

endpackage

// File: rtl/spi_shifter_if.sv
// Bus between the ctrl-code decoder / data bus read path and the SPI engine.
interface spi_shifter_if;
  logic       LOAD;
  logic       SSWR;
  logic [7:0] TXD;
  logic [1:0] SSEL;
  logic       CPOL;
  logic [2:0] MISO;
  logic       SCK;
  logic       MOSI;
  logic [1:0] nSS;
  logic [7:0] RXD;
  logic       BUSY;
  logic       DONE;

  modport master (
    output LOAD, SSWR, TXD, SSEL, CPOL, MISO,
    input  SCK, MOSI, nSS, RXD, BUSY, DONE
  );

  modport slave (
    input  LOAD, SSWR, TXD, SSEL, CPOL, MISO,
    output SCK, MOSI, nSS, RXD, BUSY, DONE
  );
endinterface

// File: rtl/spi_miso_sel.sv
// Combinational MISO mux; also reused by the status read path.
module spi_miso_sel
  import spi_shifter_pkg::*;
(
  input  logic [2:0] miso,
  input  logic [1:0] nss,
  output logic       misox
);

  assign misox = miso_mux(miso, nss);

endmodule

// File: rtl/spi_shifter.sv
// SPI byte engine (CPHA=0, MSB first). A LOAD strobe starts one byte;
// SCK half-period is DIV CLKx4 cycles, so a byte takes 16*DIV cycles
// plus one DONE cycle. All outputs come straight from registers.
module spi_shifter
  import spi_shifter_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic         CLKx4,
  input  logic         nRST,
  spi_shifter_if.slave bus
);

  localparam logic [3:0] DIV_RELOAD = 4'(DIV - 1);

  state_t     state_r, state_s;
  logic [3:0] divcnt_r, divcnt_s;
  logic [2:0] bitcnt_r, bitcnt_s;
  logic [7:0] tx_r, tx_s;
  logic [7:0] rx_r, rx_s;
  logic       cpol_r, cpol_s;
  logic       sck_r, sck_s;
  logic       mosi_r, mosi_s;
  logic [1:0] nss_r, nss_s;
  logic [7:0] rxd_r, rxd_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       misox_s;
  logic       div_zero_s;

  spi_miso_sel u_miso_sel (
    .miso  (bus.MISO),
    .nss   (nss_r),
    .misox (misox_s)
  );

  assign div_zero_s = (divcnt_r == 4'd0);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLKx4) begin
    if (!nRST) begin
      state_r  <= ST_IDLE;
      divcnt_r <= 4'd0;
      bitcnt_r <= 3'd0;
      tx_r     <= 8'h00;
      rx_r     <= 8'h00;
      cpol_r   <= 1'b0;
      sck_r    <= 1'b0;
      mosi_r   <= 1'b0;
      nss_r    <= NSS_IDLE;
      rxd_r    <= 8'h00;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      divcnt_r <= divcnt_s;
      bitcnt_r <= bitcnt_s;
      tx_r     <= tx_s;
      rx_r     <= rx_s;
      cpol_r   <= cpol_s;
      sck_r    <= sck_s;
      mosi_r   <= mosi_s;
      nss_r    <= nss_s;
      rxd_r    <= rxd_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Next-state logic: one LEAD and one TRAIL phase per bit, then DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.LOAD) begin
          state_s = ST_LEAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (div_zero_s) begin
          state_s = ST_TRAIL;
        end else begin
          state_s = ST_LEAD;
        end
      end
      ST_TRAIL: begin
        if (!div_zero_s) begin
          state_s = ST_TRAIL;
        end else if (bitcnt_r != 3'd0) begin
          state_s = ST_LEAD;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of counters, shift registers and outputs for each state.
  always_comb begin
    divcnt_s = divcnt_r;
    bitcnt_s = bitcnt_r;
    tx_s     = tx_r;
    rx_s     = rx_r;
    cpol_s   = cpol_r;
    sck_s    = sck_r;
    mosi_s   = mosi_r;
    nss_s    = nss_r;
    rxd_s    = rxd_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.LOAD) begin
          // LOAD wins over a simultaneous SSWR; both carry the same fields.
          tx_s     = bus.TXD;
          nss_s    = bus.SSEL;
          cpol_s   = bus.CPOL;
          sck_s    = bus.CPOL;
          mosi_s   = bus.TXD[7];
          busy_s   = 1'b1;
          bitcnt_s = 3'd7;
          divcnt_s = DIV_RELOAD;
        end else if (bus.SSWR) begin
          nss_s  = bus.SSEL;
          cpol_s = bus.CPOL;
          sck_s  = bus.CPOL;
        end else begin
          sck_s = cpol_r;
        end
      end
      ST_LEAD: begin
        if (div_zero_s) begin
          // Leading edge: sample the selected MISO line.
          sck_s    = ~cpol_r;
          rx_s     = {rx_r[6:0], misox_s};
          divcnt_s = DIV_RELOAD;
        end else begin
          divcnt_s = divcnt_r - 4'd1;
        end
      end
      ST_TRAIL: begin
        if (!div_zero_s) begin
          divcnt_s = divcnt_r - 4'd1;
        end else if (bitcnt_r != 3'd0) begin
          // Trailing edge: present the next bit.
          sck_s    = cpol_r;
          tx_s     = {tx_r[6:0], 1'b0};
          mosi_s   = tx_r[6];
          bitcnt_s = bitcnt_r - 3'd1;
          divcnt_s = DIV_RELOAD;
        end else begin
          // Final trailing edge: publish the byte.
          sck_s  = cpol_r;
          rxd_s  = rx_r;
          busy_s = 1'b0;
          done_s = 1'b1;
        end
      end
      ST_DONE: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign bus.SCK  = sck_r;
  assign bus.MOSI = mosi_r;
  assign bus.nSS  = nss_r;
  assign bus.RXD  = rxd_r;
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;

endmodule

// File: tb/tb_spi_shifter.sv
// Scoreboard bench for spi_shifter: stimulus pushes the expected byte
// exchange, a monitor watches SCK/MOSI/DONE and compares on each DONE.
module tb_spi_shifter;

  localparam int DIV = 2;

  typedef struct {
    logic [7:0] txd;
    logic [7:0] rxd;
    logic [1:0] nss;
    logic       cpol;
    int         e0;
  } exp_t;

  logic clk;
  logic nrst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  spi_shifter_if bus ();

  spi_shifter #(.DIV(DIV)) dut (
    .CLKx4 (clk),
    .nRST  (nrst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Byte the master should receive: each selected card contributes its
  // byte; the expansion byte is heard only with both cards deselected.
  function automatic logic [7:0] model_rx(input logic [1:0] ssel, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] r;
    r = 8'h00;
    if (ssel[0] == 1'b0) r = r | b0;
    if (ssel[1] == 1'b0) r = r | b1;
    if (ssel == 2'b11)   r = r | b2;
    return r;
  endfunction

  // ---------------- monitor ----------------
  int         lead_t[8];
  int         trail_t[8];
  int         n_lead;
  int         n_trail;
  logic [7:0] mosi_cap;
  logic       prev_sck;
  logic       prev_done;

  always @(negedge clk) begin
    exp_t e;
    if (!nrst) begin
      n_lead    = 0;
      n_trail   = 0;
      prev_sck  = bus.SCK;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_one_cycle", {31'd0, bus.DONE}, 32'd0);
      if (bus.SCK !== prev_sck && exp_q.size() > 0 && (bus.BUSY || bus.DONE)) begin
        if (bus.SCK !== exp_q[0].cpol) begin
          if (n_lead < 8) lead_t[n_lead] = cyc;
          n_lead   = n_lead + 1;
          mosi_cap = {mosi_cap[6:0], bus.MOSI};
        end else if (n_lead > 0) begin
          if (n_trail < 8) trail_t[n_trail] = cyc;
          n_trail = n_trail + 1;
        end
      end
      if (bus.DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, bus.DONE}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rxd", {24'd0, bus.RXD}, {24'd0, e.rxd});
          chk("mosi_bits", {24'd0, mosi_cap}, {24'd0, e.txd});
          chk("mosi_hold", {31'd0, bus.MOSI}, {31'd0, e.txd[0]});
          chk("nss", {30'd0, bus.nSS}, {30'd0, e.nss});
          chk("busy_at_done", {31'd0, bus.BUSY}, 32'd0);
          chk("sck_idle_at_done", {31'd0, bus.SCK}, {31'd0, e.cpol});
          chk("done_edge", cyc, e.e0 + 16 * DIV);
          chk("lead_count", n_lead, 8);
          chk("trail_count", n_trail, 8);
          for (int k = 0; k < 8; k++) begin
            chk("lead_edge", lead_t[k], e.e0 + (2 * k + 1) * DIV);
            chk("trail_edge", trail_t[k], e.e0 + (2 * k + 2) * DIV);
          end
        end
        n_lead  = 0;
        n_trail = 0;
      end
      prev_sck  = bus.SCK;
      prev_done = bus.DONE;
    end
  end

  // ---------------- stimulus ----------------
  task automatic sswr(input logic [1:0] ssel, input logic cpol);
    @(negedge clk);
    bus.SSWR = 1'b1;
    bus.SSEL = ssel;
    bus.CPOL = cpol;
    @(negedge clk);
    bus.SSWR = 1'b0;
    chk("sswr_nss", {30'd0, bus.nSS}, {30'd0, ssel});
    chk("sswr_sck", {31'd0, bus.SCK}, {31'd0, cpol});
    chk("sswr_busy", {31'd0, bus.BUSY}, 32'd0);
  endtask

  // mode 0: plain byte, 1: ignored LOAD/SSWR mid-byte, 2: reset at edge 10
  task automatic xfer(input logic [7:0] txd, input logic [1:0] ssel, input logic cpol,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int mode);
    exp_t e;
    int   k;
    @(negedge clk);
    bus.TXD  = txd;
    bus.SSEL = ssel;
    bus.CPOL = cpol;
    bus.LOAD = 1'b1;
    bus.MISO = {b2[7], b1[7], b0[7]};
    @(negedge clk);
    bus.LOAD = 1'b0;
    chk("busy_after_load", {31'd0, bus.BUSY}, 32'd1);
    chk("mosi_bit7_at_load", {31'd0, bus.MOSI}, {31'd0, txd[7]});
    if (mode != 2) begin
      e.txd  = txd;
      e.rxd  = model_rx(ssel, b0, b1, b2);
      e.nss  = ssel;
      e.cpol = cpol;
      e.e0   = cyc;
      exp_q.push_back(e);
    end
    for (int j = 1; j <= 16 * DIV; j++) begin
      @(negedge clk);
      if (j % (2 * DIV) == 0 && j < 16 * DIV) begin
        k = j / (2 * DIV);
        bus.MISO = {b2[7 - k], b1[7 - k], b0[7 - k]};
      end
      if (mode == 1) begin
        if (j == 5) begin
          bus.TXD = 8'h12; bus.SSEL = ~ssel; bus.CPOL = ~cpol; bus.LOAD = 1'b1;
        end
        if (j == 6) bus.LOAD = 1'b0;
        if (j == 7) begin
          bus.SSEL = 2'b11; bus.CPOL = ~cpol; bus.SSWR = 1'b1;
        end
        if (j == 8) begin
          bus.SSWR = 1'b0;
          chk("nss_mid_ignored", {30'd0, bus.nSS}, {30'd0, ssel});
        end
      end
      if (mode == 2) begin
        if (j == 9) nrst = 1'b0;
        if (j == 10) begin
          chk("rst_mid_sck", {31'd0, bus.SCK}, 32'd0);
          chk("rst_mid_mosi", {31'd0, bus.MOSI}, 32'd0);
          chk("rst_mid_nss", {30'd0, bus.nSS}, 32'd3);
          chk("rst_mid_rxd", {24'd0, bus.RXD}, 32'd0);
          chk("rst_mid_busy", {31'd0, bus.BUSY}, 32'd0);
          chk("rst_mid_done", {31'd0, bus.DONE}, 32'd0);
          nrst = 1'b1;
          break;
        end
      end
    end
    if (mode == 2) begin
      repeat (16 * DIV + 8) @(negedge clk);
    end else begin
      for (int t = 0; t < 8 && exp_q.size() != 0; t++) @(negedge clk);
      chk("done_seen", exp_q.size(), 32'd0);
      exp_q.delete();
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1, r2, rt;
    logic [1:0] rs;
    logic       rc;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    bus.LOAD = 1'b0;
    bus.SSWR = 1'b0;
    bus.TXD  = 8'h00;
    bus.SSEL = 2'b11;
    bus.CPOL = 1'b0;
    bus.MISO = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_sck", {31'd0, bus.SCK}, 32'd0);
    chk("rst_mosi", {31'd0, bus.MOSI}, 32'd0);
    chk("rst_nss", {30'd0, bus.nSS}, 32'd3);
    chk("rst_rxd", {24'd0, bus.RXD}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'd0, bus.DONE}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Card 0 replays 3C while A5 goes out.
    xfer(8'hA5, 2'b10, 1'b0, 8'h3C, 8'($urandom), 8'($urandom), 0);
    // Idle-high clock, card 1 silent, other lines noisy.
    sswr(2'b01, 1'b1);
    xfer(8'hFF, 2'b01, 1'b1, 8'hC3, 8'h00, 8'h5A, 0);
    // Mid-byte LOAD and SSWR are ignored.
    xfer(8'h96, 2'b10, 1'b0, 8'h81, 8'h7E, 8'hE7, 1);
    // Reset at edge 10 aborts the byte with no DONE.
    xfer(8'h5A, 2'b10, 1'b0, 8'hF0, 8'h0F, 8'hAA, 2);
    // Both cards deselected: expansion line is sampled.
    sswr(2'b11, 1'b0);
    xfer(8'h3C, 2'b11, 1'b0, 8'hFF, 8'hFF, 8'h69, 0);

    for (int i = 0; i < 12; i++) begin
      rt = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      xfer(rt, rs, rc, r0, r1, r2, 0);
    end
    sswr(2'b11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
